// File: rtl/tinyalu_pkg.sv
// Shared types and constants for the ALU result checker.
package tinyalu_pkg;

    // Width of the match/mismatch counters.
    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        StRun,
        StHalt
    } chk_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/alu_result_checker_if.sv
// Valid/ready streams carrying golden (pred) and observed (act) results.
interface alu_result_checker_if #(
    parameter int unsigned RESULT_W = 16
) ();
    logic                pred_valid;
    logic [RESULT_W-1:0] pred_result;
    logic                pred_ready;
    logic                act_valid;
    logic [RESULT_W-1:0] act_result;
    logic                act_ready;

    // Producer side of both streams.
    modport master (
        output pred_valid, pred_result, act_valid, act_result,
        input  pred_ready, act_ready
    );

    // Checker side of both streams.
    modport slave (
        input  pred_valid, pred_result, act_valid, act_result,
        output pred_ready, act_ready
    );
endinterface

// File: rtl/chk_sync_fifo.sv
// Single-clock FIFO; pointers carry one extra bit to tell full from empty.
module chk_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Pointer update; clear wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_result_checker.sv
// Pairs golden and observed results from two FIFOs, compares them under a mask,
// counts matches/mismatches, reports the last mismatch and flags starvation.
module alu_result_checker
    import tinyalu_pkg::*;
#(
    parameter int unsigned RESULT_W = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_result_checker_if.slave bus,
    input  logic [RESULT_W-1:0] cmp_mask,
    input  logic                stop_on_err,
    input  logic                clear,
    output logic [CNT_W-1:0]    match_cnt,
    output logic [CNT_W-1:0]    mismatch_cnt,
    output logic                err_pulse,
    output logic [RESULT_W-1:0] err_pred,
    output logic [RESULT_W-1:0] err_act,
    output logic                timeout_err,
    output logic                halted
);
    localparam int unsigned       TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_MAX = TO_W'(TIMEOUT);

    chk_state_e          r_state;
    chk_state_e          w_state_nxt;
    logic                r_rdy_en;
    logic                w_pred_full, w_pred_empty, w_act_full, w_act_empty;
    logic [RESULT_W-1:0] w_pred_head, w_act_head;
    logic                w_pred_push, w_act_push, w_pop;
    logic                r_cmp_vld;
    logic [RESULT_W-1:0] r_cmp_pred, r_cmp_act, r_cmp_mask;
    logic                w_mismatch, w_match, w_halt_now;
    logic [CNT_W-1:0]    r_match_cnt, r_mismatch_cnt;
    logic                r_err_pulse;
    logic [RESULT_W-1:0] r_err_pred, r_err_act;
    logic [TO_W-1:0]     r_to_cnt;
    logic [TO_W-1:0]     w_to_next;
    logic                r_timeout_err;

    assign bus.pred_ready = r_rdy_en & ~w_pred_full & (r_state == StRun);
    assign bus.act_ready  = r_rdy_en & ~w_act_full & (r_state == StRun);
    assign w_pred_push    = bus.pred_valid & bus.pred_ready;
    assign w_act_push     = bus.act_valid & bus.act_ready;

    assign w_mismatch = r_cmp_vld & (|((r_cmp_pred ^ r_cmp_act) & r_cmp_mask));
    assign w_match    = r_cmp_vld & ~(|((r_cmp_pred ^ r_cmp_act) & r_cmp_mask));
    assign w_halt_now = w_mismatch & stop_on_err;
    // Block the pop in the cycle a stopping mismatch is seen so nothing more is consumed.
    assign w_pop      = (r_state == StRun) & ~w_pred_empty & ~w_act_empty &
                        ~w_halt_now & ~clear;
    assign w_to_next  = (r_to_cnt == TO_MAX) ? r_to_cnt : r_to_cnt + 1'b1;

    chk_sync_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (DEPTH)
    ) u_pred_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (clear),
        .i_push  (w_pred_push),
        .i_wdata (bus.pred_result),
        .i_pop   (w_pop),
        .o_rdata (w_pred_head),
        .o_full  (w_pred_full),
        .o_empty (w_pred_empty)
    );

    chk_sync_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (DEPTH)
    ) u_act_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (clear),
        .i_push  (w_act_push),
        .i_wdata (bus.act_result),
        .i_pop   (w_pop),
        .o_rdata (w_act_head),
        .o_full  (w_act_full),
        .o_empty (w_act_empty)
    );

    // Readies stay low in reset and rise on the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rdy_en <= 1'b0;
        else          r_rdy_en <= 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= StRun;
        else          r_state <= w_state_nxt;
    end

    // FSM next state: clear always returns to RUN, stopping mismatch enters HALT.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = StRun;
        end else if ((r_state == StRun) && w_halt_now) begin
            w_state_nxt = StHalt;
        end
    end

    // Compare stage: capture the popped pair and the mask in force at pop time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmp_vld  <= 1'b0;
            r_cmp_pred <= '0;
            r_cmp_act  <= '0;
            r_cmp_mask <= '0;
        end else begin
            r_cmp_vld <= w_pop;
            if (w_pop) begin
                r_cmp_pred <= w_pred_head;
                r_cmp_act  <= w_act_head;
                r_cmp_mask <= cmp_mask;
            end
        end
    end

    // Result bookkeeping: counters, error pulse and last-mismatch capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_match_cnt    <= '0;
            r_mismatch_cnt <= '0;
            r_err_pulse    <= 1'b0;
            r_err_pred     <= '0;
            r_err_act      <= '0;
        end else if (clear) begin
            r_match_cnt    <= '0;
            r_mismatch_cnt <= '0;
            r_err_pulse    <= 1'b0;
            r_err_pred     <= '0;
            r_err_act      <= '0;
        end else begin
            r_err_pulse <= w_mismatch;
            if (w_match) r_match_cnt <= sat_inc(r_match_cnt);
            if (w_mismatch) begin
                r_mismatch_cnt <= sat_inc(r_mismatch_cnt);
                r_err_pred     <= r_cmp_pred;
                r_err_act      <= r_cmp_act;
            end
        end
    end

    // Starvation watchdog: counts while exactly one FIFO holds data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else if (clear) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else if (w_pred_empty ^ w_act_empty) begin
            r_to_cnt <= w_to_next;
            if (w_to_next == TO_MAX) r_timeout_err <= 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign match_cnt    = r_match_cnt;
    assign mismatch_cnt = r_mismatch_cnt;
    assign err_pulse    = r_err_pulse;
    assign err_pred     = r_err_pred;
    assign err_act      = r_err_act;
    assign timeout_err  = r_timeout_err;
    assign halted       = (r_state == StHalt);

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker with a queue-based reference model.
module tb_alu_result_checker;
    localparam int unsigned W       = 16;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 255;

    logic          clk;
    logic          reset_n;
    logic [W-1:0]  cmp_mask;
    logic          stop_on_err;
    logic          clear;
    logic [15:0]   match_cnt, mismatch_cnt;
    logic          err_pulse;
    logic [W-1:0]  err_pred, err_act;
    logic          timeout_err, halted;

    int n_checks = 0;
    int n_pass   = 0;

    alu_result_checker_if #(.RESULT_W(W)) bus ();

    alu_result_checker #(
        .RESULT_W (W),
        .DEPTH    (DEPTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .cmp_mask     (cmp_mask),
        .stop_on_err  (stop_on_err),
        .clear        (clear),
        .match_cnt    (match_cnt),
        .mismatch_cnt (mismatch_cnt),
        .err_pulse    (err_pulse),
        .err_pred     (err_pred),
        .err_act      (err_act),
        .timeout_err  (timeout_err),
        .halted       (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        else n_pass++;
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] qp[$];
    logic [W-1:0] qa[$];
    int           m_match, m_mis, m_to;
    bit           m_pulse, m_toerr, m_halt, m_rdy;
    logic [W-1:0] m_err_pred, m_err_act;
    bit           m_inf_v;
    logic [W-1:0] m_inf_p, m_inf_a, m_inf_m;

    function automatic int sat16(input int v);
        return (v >= 16'hFFFF) ? 16'hFFFF : v + 1;
    endfunction

    task automatic model_zero();
        qp.delete();
        qa.delete();
        m_match = 0; m_mis = 0; m_to = 0;
        m_pulse = 0; m_toerr = 0; m_halt = 0; m_inf_v = 0;
        m_err_pred = '0; m_err_act = '0;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_zero();
            m_rdy = 0;
        end else if (clear) begin
            model_zero();
            m_rdy = 1;
        end else begin
            bit prdy, ardy, one_busy, mism, stop_now;
            prdy     = m_rdy && (qp.size() < DEPTH) && !m_halt;
            ardy     = m_rdy && (qa.size() < DEPTH) && !m_halt;
            one_busy = (qp.size() != 0) != (qa.size() != 0);
            mism     = m_inf_v && (((m_inf_p ^ m_inf_a) & m_inf_m) != 0);
            if (m_inf_v) begin
                if (mism) begin
                    m_mis      = sat16(m_mis);
                    m_err_pred = m_inf_p;
                    m_err_act  = m_inf_a;
                end else begin
                    m_match = sat16(m_match);
                end
            end
            m_pulse  = mism;
            stop_now = mism && stop_on_err;
            if (!m_halt && !stop_now && qp.size() > 0 && qa.size() > 0) begin
                m_inf_v = 1;
                m_inf_p = qp.pop_front();
                m_inf_a = qa.pop_front();
                m_inf_m = cmp_mask;
            end else begin
                m_inf_v = 0;
            end
            if (stop_now) m_halt = 1;
            if (one_busy) begin
                if (m_to < int'(TIMEOUT)) m_to++;
                if (m_to >= int'(TIMEOUT)) m_toerr = 1;
            end else begin
                m_to = 0;
            end
            if (bus.pred_valid && prdy) qp.push_back(bus.pred_result);
            if (bus.act_valid && ardy)  qa.push_back(bus.act_result);
            m_rdy = 1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("pred_ready",   bus.pred_ready, m_rdy && (qp.size() < DEPTH) && !m_halt);
        check("act_ready",    bus.act_ready,  m_rdy && (qa.size() < DEPTH) && !m_halt);
        check("match_cnt",    match_cnt,      m_match);
        check("mismatch_cnt", mismatch_cnt,   m_mis);
        check("err_pulse",    err_pulse,      m_pulse);
        check("err_pred",     err_pred,       m_err_pred);
        check("err_act",      err_act,        m_err_act);
        check("timeout_err",  timeout_err,    m_toerr);
        check("halted",       halted,         m_halt);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic pv, input logic [W-1:0] p, input logic av, input logic [W-1:0] a);
        bus.pred_valid  = pv;
        bus.pred_result = p;
        bus.act_valid   = av;
        bus.act_result  = a;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; stop_on_err = 1'b0; cmp_mask = 16'hFFFF;
        bus.pred_valid = 1'b0; bus.pred_result = '0;
        bus.act_valid  = 1'b0; bus.act_result  = '0;
        repeat (3) @(negedge clk);
        check("rst_pred_ready_low", bus.pred_ready, 0);
        check("rst_act_ready_low",  bus.act_ready,  0);
        reset_n = 1'b1;
        #1 check("ready_low_before_edge", bus.pred_ready, 0);
        @(negedge clk);
        check("ready_high_after_edge", bus.pred_ready, 1);
        check("reset_match_cnt",       match_cnt,      0);
        check("reset_timeout_err",     timeout_err,    0);

        // Single matching pair: counted two cycles after the push.
        cyc(1'b1, 16'h0012, 1'b1, 16'h0012);
        idle(2);
        check("equal_match_cnt",    match_cnt,    1);
        check("equal_mismatch_cnt", mismatch_cnt, 0);
        check("equal_no_err_pulse", err_pulse,    0);

        // Mismatch with full mask, then same pair with low-byte mask.
        do_clear();
        cyc(1'b1, 16'h00FF, 1'b1, 16'h01FF);
        idle(2);
        check("diff_mismatch_cnt", mismatch_cnt, 1);
        check("diff_err_pred",     err_pred,     16'h00FF);
        check("diff_err_act",      err_act,      16'h01FF);
        check("diff_err_pulse",    err_pulse,    1);
        idle(1);
        check("diff_pulse_one_cycle", err_pulse, 0);
        cmp_mask = 16'h00FF;
        cyc(1'b1, 16'h00FF, 1'b1, 16'h01FF);
        idle(2);
        check("masked_match_cnt", match_cnt,    1);
        check("masked_mis_held",  mismatch_cnt, 1);
        cmp_mask = 16'hFFFF;

        // Back-to-back pairs across several pointer wraps.
        do_clear();
        for (int i = 0; i < 20; i++) begin
            check("b2b_ready", bus.pred_ready, 1);
            cyc(1'b1, 16'(i * 16'h0101 + 3), 1'b1, 16'(i * 16'h0101 + 3));
        end
        idle(3);
        check("b2b_match_cnt",    match_cnt,    20);
        check("b2b_mismatch_cnt", mismatch_cnt, 0);

        // Stop on error: mismatch followed by three queued pairs.
        do_clear();
        stop_on_err = 1'b1;
        cyc(1'b1, 16'h0001, 1'b1, 16'h0002);
        cyc(1'b1, 16'h0005, 1'b1, 16'h0005);
        cyc(1'b1, 16'h0006, 1'b1, 16'h0006);
        cyc(1'b1, 16'h0007, 1'b1, 16'h0007);
        idle(4);
        check("halt_halted",    halted,         1);
        check("halt_pred_rdy",  bus.pred_ready, 0);
        check("halt_act_rdy",   bus.act_ready,  0);
        check("halt_mis_cnt",   mismatch_cnt,   1);
        check("halt_match_cnt", match_cnt,      0);
        idle(5);
        check("halt_frozen_match", match_cnt, 0);
        do_clear();
        stop_on_err = 1'b0;
        check("clr_halted",    halted,         0);
        check("clr_pred_rdy",  bus.pred_ready, 1);
        check("clr_mis_cnt",   mismatch_cnt,   0);
        check("clr_err_pred",  err_pred,       0);

        // Fill pred FIFO with no act: full and starvation timeout.
        do_clear();
        for (int k = 0; k < 8; k++) cyc(1'b1, 16'(16'h00A0 + k), 1'b0, '0);
        check("full_pred_ready", bus.pred_ready, 0);
        check("full_act_ready",  bus.act_ready,  1);
        cyc(1'b1, 16'hBEEF, 1'b0, '0);
        idle(246);
        check("timeout_not_yet", timeout_err, 0);
        idle(1);
        check("timeout_set", timeout_err, 1);
        for (int k = 0; k < 8; k++) cyc(1'b0, '0, 1'b1, 16'(16'h00A0 + k));
        idle(3);
        check("drain_match_cnt",   match_cnt,    8);
        check("drain_timeout_err", timeout_err,  1);
        check("drain_mis_cnt",     mismatch_cnt, 0);

        // Asynchronous reset with entries queued.
        do_clear();
        cyc(1'b1, 16'h0033, 1'b1, 16'h0033);
        idle(2);
        check("pre_rst_match", match_cnt, 1);
        for (int k = 0; k < 3; k++) cyc(1'b1, 16'h0055, 1'b0, '0);
        bus.pred_valid = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_match",    match_cnt,      0);
        check("async_rst_timeout",  timeout_err,    0);
        check("async_rst_pred_rdy", bus.pred_ready, 0);
        check("async_rst_pulse",    err_pulse,      0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        cyc(1'b1, 16'h0077, 1'b0, '0);
        cyc(1'b0, '0, 1'b1, 16'h0077);
        idle(3);
        check("post_rst_match", match_cnt,    1);
        check("post_rst_mis",   mismatch_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
